// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit for the EX stage. It owns the
//            HI/LO registers and raises busy while a mult/div is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;

  localparam logic [CW-1:0] c_MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] c_DIV_LOAD  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] c_ONE       = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic [63:0]   w_sprod;
  logic [63:0]   w_uprod;
  logic [31:0]   w_divisor;
  logic          w_div_ovf;
  logic [31:0]   w_squot, w_srem;
  logic [31:0]   w_uquot, w_urem;

  // Products and quotients from the raw operands; only latched on accept.
  always_comb begin
    w_sprod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    w_uprod   = {32'b0, a} * {32'b0, b};
    // Divide-by-zero never commits, so a dummy divisor keeps the dividers defined.
    w_divisor = (b == 32'b0) ? 32'd1 : b;
    // Most-negative / -1 overflows the signed divider; pin the architectural result.
    w_div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    w_squot   = w_div_ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(w_divisor));
    w_srem    = w_div_ovf ? 32'h0000_0000 : 32'($signed(a) % $signed(w_divisor));
    w_uquot   = a / w_divisor;
    w_urem    = a % w_divisor;
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Next-state: accept ops in IDLE, count down in BUSY and commit at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            c_OP_MULT, c_OP_MULTU: begin
              pend_hi_d = (md_op == c_OP_MULT) ? w_sprod[63:32] : w_uprod[63:32];
              pend_lo_d = (md_op == c_OP_MULT) ? w_sprod[31:0]  : w_uprod[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = c_MULT_LOAD;
              state_d   = S_BUSY;
            end
            c_OP_DIV, c_OP_DIVU: begin
              pend_hi_d = (md_op == c_OP_DIV) ? w_srem  : w_urem;
              pend_lo_d = (md_op == c_OP_DIV) ? w_squot : w_uquot;
              // A zero divisor still occupies the unit but leaves HI/LO alone.
              pend_wr_d = (b != 32'b0);
              cnt_d     = c_DIV_LOAD;
              state_d   = S_BUSY;
            end
            c_OP_MTHI: hi_d = a;
            c_OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - c_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Directed vector bench for md_unit (HI/LO, busy timing, reset abort).
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues one op and waits until busy drops again.
  task automatic run_op(input int idx, input vec_t v);
    int          cyc;
    logic        held;
    logic [31:0] hi0, lo0;
    hi0   = hi;
    lo0   = lo;
    held  = 1'b1;
    start = 1'b1;
    md_op = v.op;
    a     = v.a;
    b     = v.b;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("vec%0d busy_cycles", idx), 32'(cyc), 32'(v.cyc));
    chk($sformatf("vec%0d hold", idx), {31'b0, held}, 32'd1);
    chk($sformatf("vec%0d hi", idx), hi, v.hi);
    chk($sformatf("vec%0d lo", idx), lo, v.lo);
  endtask

  initial begin
    logic leak;
    start = 1'b0;
    md_op = 3'd6;
    a     = '0;
    b     = '0;
    reset = 1'b0;

    // Reset for one edge.
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b1;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{3'd3, 32'd7,         32'd2,          32'h0000_0001, 32'h0000_0003, 10};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 10};
    vecs[5]  = '{3'd0, 32'h0001_0000, 32'h0001_0000,  32'h0000_0001, 32'h0000_0000, 5};
    vecs[6]  = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[7]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[8]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 5};
    vecs[9]  = '{3'd4, 32'h0000_00AA, 32'h1111_1111,  32'h0000_00AA, 32'h0000_0001, 0};
    vecs[10] = '{3'd5, 32'h0000_00BB, 32'h2222_2222,  32'h0000_00AA, 32'h0000_00BB, 0};
    vecs[11] = '{3'd3, 32'd5,         32'd0,          32'h0000_00AA, 32'h0000_00BB, 10};
    vecs[12] = '{3'd2, 32'hFFFF_FFF0, 32'd0,          32'h0000_00AA, 32'h0000_00BB, 10};
    vecs[13] = '{3'd6, 32'h1234_5678, 32'd3,          32'h0000_00AA, 32'h0000_00BB, 0};
    vecs[14] = '{3'd7, 32'h8765_4321, 32'd9,          32'h0000_00AA, 32'h0000_00BB, 0};

    // Back-to-back issue: each op starts on the first cycle busy is low.
    for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

    // mthi then mtlo on consecutive cycles; busy never rises.
    start = 1'b1; md_op = 3'd4; a = 32'h0000_1234; b = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mthi busy", {31'b0, busy}, 32'd0);
    chk("mthi hi", hi, 32'h0000_1234);
    md_op = 3'd5; a = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo busy", {31'b0, busy}, 32'd0);
    chk("mtlo hi", hi, 32'h0000_1234);
    chk("mtlo lo", lo, 32'h0000_5678);

    // Mult accepted, mtlo attempted while busy, then reset aborts the mult.
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    chk("abort busy1", {31'b0, busy}, 32'd1);
    md_op = 3'd5; a = 32'h0000_0077;
    @(negedge clk);
    start = 1'b0;
    chk("ignored mtlo lo", lo, 32'h0000_5678);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    leak = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) leak = 1'b1;
    end
    chk("no late commit", {31'b0, leak}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
